// File: rtl/uart_rx_sink_if.sv
// uart_rx_sink_if: valid/ready byte stream from the UART receiver FIFO
interface uart_rx_sink_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master(output rx_data, rx_valid, input rx_ready);
  modport slave(input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 8N1 UART receiver feeding a byte FIFO read out over valid/ready
module uart_rx_sink #(
  parameter int ClockFrequency = 125_000_000,
  parameter int BaudRate       = 15_625_000,
  parameter int FifoDepth      = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rx_i,
  input  logic           clr_err_i,
  output logic           busy_o,
  output logic           frame_err_o,
  output logic           overflow_o,
  uart_rx_sink_if.master rx_if
);
  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int CW = $clog2(ClksPerBit);
  localparam int AW = $clog2(FifoDepth);
  localparam logic [CW-1:0] HalfLoad = CW'(ClksPerBit / 2 - 1);
  localparam logic [CW-1:0] FullLoad = CW'(ClksPerBit - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_WAIT = 3'd4;
  logic [1:0]    sync;
  logic          rxs, rxs_q, fall, tick, push, pop, full, empty, wr_en;
  logic [2:0]    state, idx;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [FifoDepth];
  assign rxs   = sync[1];
  assign fall  = rxs_q & ~rxs;
  assign tick  = cnt == '0;
  assign push  = state == S_STOP && tick && rxs;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && rx_if.rx_ready;
  assign wr_en = push && (!full || pop);
  assign busy_o = state != S_IDLE;
  assign rx_if.rx_valid = !empty;
  assign rx_if.rx_data  = mem[rd_ptr[AW-1:0]];
  // two-flop synchronizer plus one delayed copy for start-edge detection; idles high
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sync  <= 2'b11;
      rxs_q <= 1'b1;
    end else begin
      sync  <= {sync[0], rx_i};
      rxs_q <= rxs;
    end
  // frame FSM: mid-bit sampling driven by a down-counter reloaded every bit period
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= state == S_STOP && tick && !rxs;
      cnt         <= tick ? FullLoad : cnt - 1'b1;
      case (state)
        S_IDLE: begin
          if (fall) state <= S_START;
          if (fall) cnt <= HalfLoad;
        end
        S_START: if (tick) begin
          state <= rxs ? S_IDLE : S_DATA;
          idx   <= '0;
        end
        S_DATA: if (tick) begin
          shreg <= {rxs, shreg[7:1]};
          idx   <= idx + 1'b1;
          if (idx == 3'd7) state <= S_STOP;
        end
        S_STOP: if (tick) state <= rxs ? S_IDLE : S_WAIT;
        S_WAIT: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  // byte FIFO with extra pointer MSB for full/empty; a pop frees room for a same-cycle push
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem        <= '{default: '0};
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overflow_o <= (push && full && !pop) || (overflow_o && !clr_err_i);
    end
endmodule
